// File: rtl/fp_pkg.sv
// rtl/fp_pkg.sv - shared types, constants and packing helper for the float add/sub controller
//
// Contents:
//   EXP_W, FRAC_W, MANT_W, BIAS   IEEE-754 single-precision field geometry
//   QNAN, PINF                    canonical quiet NaN and +infinity encodings
//   SHIFT_CAP                     alignment distance at which the small mantissa is simply cleared
//   state_t                       sequencing FSM states
//   fp_op_t                       unpacked operand {sign, exp, mant-with-hidden-bit}
//   fp_pack()                     pack sign/exponent/mantissa, saturating to infinity
package fp_pkg;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int MANT_W = FRAC_W + 1;
    localparam int BIAS   = 127;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;
    localparam logic [31:0] PINF = 32'h7F80_0000;

    // A 24-bit mantissa shifted right by 25 or more is all zeros.
    localparam logic [EXP_W-1:0] SHIFT_CAP = 8'd25;

    typedef enum logic [2:0] {
        S_IDLE,
        S_UNPACK,
        S_ALIGN,
        S_LOAD,
        S_EXEC,
        S_CAPT,
        S_NORM,
        S_PACK
    } state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [MANT_W-1:0] mant;
    } fp_op_t;

    // Exponent carries one extra bit so a carry out of 254 is seen as overflow.
    function automatic logic [31:0] fp_pack(input logic              sign,
                                            input logic [EXP_W:0]    exp,
                                            input logic [FRAC_W-1:0] frac);
        if (exp >= 9'd255)
            fp_pack = PINF | {sign, 31'd0};
        else
            fp_pack = {sign, exp[EXP_W-1:0], frac};
    endfunction

endpackage

// File: rtl/fp_addsub_ctrl_if.sv
// rtl/fp_addsub_ctrl_if.sv - request/response handshake between calculator FSM and float add/sub unit
//
// Signals:
//   start   one-cycle request, honoured only while the unit is idle
//   op      0 = a+b, 1 = a-b
//   a, b    packed single-precision operands, captured with start
//   busy    high while an operation is in flight
//   done    one-cycle completion pulse, result valid in the same cycle
//   result  packed single-precision result, stable until the next accepted start
// Modports: master (requester), slave (the add/sub controller).
interface fp_addsub_ctrl_if;

    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (output start, op, a, b, input busy, done, result);
    modport slave  (input start, op, a, b, output busy, done, result);

endinterface

// File: rtl/fp_unpack.sv
// rtl/fp_unpack.sv - combinational classify/unpack of one packed single-precision operand
//
// Ports:
//   x        in   packed operand
//   u        out  {sign, exp, mant}; mant includes the hidden bit, zero for exp==0
//   is_zero  out  exponent field is 0 (denormals are flushed to zero)
//   is_inf   out  exponent all ones, fraction zero
//   is_nan   out  exponent all ones, fraction non-zero
module fp_unpack
    import fp_pkg::*;
(
    input  logic [31:0] x,
    output fp_op_t      u,
    output logic        is_zero,
    output logic        is_inf,
    output logic        is_nan
);

    logic [EXP_W-1:0]  e;
    logic [FRAC_W-1:0] f;

    assign e = x[30:23];
    assign f = x[22:0];

    assign is_zero = (e == '0);
    assign is_inf  = (e == '1) && (f == '0);
    assign is_nan  = (e == '1) && (f != '0);

    assign u = {x[31], e, (is_zero ? {MANT_W{1'b0}} : {1'b1, f})};

endmodule

// File: rtl/fp_addsub_ctrl.sv
// rtl/fp_addsub_ctrl.sv - sequencing controller turning the 24-bit mantissa adder into a float add/sub unit
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   bus        slave side of the start/done handshake (op, a, b in; busy, done, result out)
//   add_en     adder enable (LOAD and EXEC)
//   add_load   adder load strobe (LOAD only)
//   add_pm     0 = magnitude add, 1 = magnitude subtract
//   add_a      larger mantissa
//   add_b      aligned smaller mantissa
//   add_signa, add_signb, add_cin   tied low
//   add_sum    adder sum, registered by the adder at the end of EXEC
//   add_cout   adder carry out
module fp_addsub_ctrl
    import fp_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    fp_addsub_ctrl_if.slave     bus,
    output logic                add_en,
    output logic                add_load,
    output logic                add_pm,
    output logic [MANT_W-1:0]   add_a,
    output logic [MANT_W-1:0]   add_b,
    output logic                add_signa,
    output logic                add_signb,
    output logic                add_cin,
    input  logic [MANT_W-1:0]   add_sum,
    input  logic                add_cout
);

    state_t              state, state_nxt;
    logic [31:0]         a_r, a_nxt, b_r, b_nxt;
    logic                op_r, op_nxt;
    logic                sign_r, sign_nxt;
    logic                eff_r, eff_nxt;
    logic [EXP_W:0]      exp_r, exp_nxt;
    logic [MANT_W-1:0]   mant_l, mant_l_nxt;
    logic [MANT_W-1:0]   mant_s, mant_s_nxt;
    logic [MANT_W-1:0]   mant_r, mant_r_nxt;
    logic [EXP_W-1:0]    d_r, d_nxt;
    logic [31:0]         result_r, result_nxt;
    logic                busy_r, busy_nxt;
    logic                done_r, done_nxt;
    logic                en_r, en_nxt;
    logic                load_r, load_nxt;
    logic                pm_r, pm_nxt;

    fp_op_t ua, ub;
    logic   a_zero, a_inf, a_nan;
    logic   b_zero, b_inf, b_nan;
    logic   b_gt;
    logic   eff_c;

    logic [MANT_W-1:0] m_c;
    logic [EXP_W:0]    e_c;

    fp_unpack u_unpack_a (.x(a_r), .u(ua), .is_zero(a_zero), .is_inf(a_inf), .is_nan(a_nan));
    fp_unpack u_unpack_b (.x(b_r), .u(ub), .is_zero(b_zero), .is_inf(b_inf), .is_nan(b_nan));

    // Magnitude order: exponent first, then mantissa; ties keep a as the larger.
    assign b_gt  = {ub.exp, ub.mant} > {ua.exp, ua.mant};
    assign eff_c = op_r ^ ua.sign ^ ub.sign;

    always_comb begin
        state_nxt  = state;
        a_nxt      = a_r;
        b_nxt      = b_r;
        op_nxt     = op_r;
        sign_nxt   = sign_r;
        eff_nxt    = eff_r;
        exp_nxt    = exp_r;
        mant_l_nxt = mant_l;
        mant_s_nxt = mant_s;
        mant_r_nxt = mant_r;
        d_nxt      = d_r;
        result_nxt = result_r;
        m_c        = mant_r;
        e_c        = exp_r;

        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    a_nxt     = bus.a;
                    b_nxt     = bus.b;
                    op_nxt    = bus.op;
                    state_nxt = S_UNPACK;
                end
            end

            S_UNPACK: begin
                sign_nxt   = b_gt ? (ub.sign ^ op_r) : ua.sign;
                eff_nxt    = eff_c;
                exp_nxt    = {1'b0, (b_gt ? ub.exp : ua.exp)};
                mant_l_nxt = b_gt ? ub.mant : ua.mant;
                mant_s_nxt = b_gt ? ua.mant : ub.mant;
                d_nxt      = b_gt ? (ub.exp - ua.exp) : (ua.exp - ub.exp);
                state_nxt  = S_ALIGN;
                if (a_nan || b_nan || (a_inf && b_inf && eff_c)) begin
                    result_nxt = QNAN;
                    state_nxt  = S_PACK;
                end else if (a_inf) begin
                    result_nxt = PINF | {ua.sign, 31'd0};
                    state_nxt  = S_PACK;
                end else if (b_inf) begin
                    result_nxt = PINF | {(ub.sign ^ op_r), 31'd0};
                    state_nxt  = S_PACK;
                end else if (a_zero && b_zero) begin
                    result_nxt = {(ua.sign & (ub.sign ^ op_r)), 31'd0};
                    state_nxt  = S_PACK;
                end
            end

            S_ALIGN: begin
                if (d_r >= SHIFT_CAP) begin
                    mant_s_nxt = '0;
                    d_nxt      = '0;
                    state_nxt  = S_LOAD;
                end else if (d_r != '0) begin
                    mant_s_nxt = mant_s >> 1;
                    d_nxt      = d_r - 8'd1;
                    if (d_r == 8'd1)
                        state_nxt = S_LOAD;
                end else begin
                    state_nxt = S_LOAD;
                end
            end

            S_LOAD: state_nxt = S_EXEC;

            S_EXEC: state_nxt = S_CAPT;

            S_CAPT: begin
                // Subtraction never carries in a meaningful way: the larger
                // operand is always on add_a, so the sum is the true difference.
                if (!eff_r && add_cout) begin
                    m_c = {1'b1, add_sum[MANT_W-1:1]};
                    e_c = exp_r + 9'd1;
                end else begin
                    m_c = add_sum;
                    e_c = exp_r;
                end
                mant_r_nxt = m_c;
                exp_nxt    = e_c;
                if (eff_r && (add_sum == '0)) begin
                    result_nxt = '0;
                    state_nxt  = S_PACK;
                end else if (m_c[MANT_W-1]) begin
                    result_nxt = fp_pack(sign_r, e_c, m_c[FRAC_W-1:0]);
                    state_nxt  = S_PACK;
                end else begin
                    state_nxt = S_NORM;
                end
            end

            S_NORM: begin
                m_c        = mant_r << 1;
                e_c        = exp_r - 9'd1;
                mant_r_nxt = m_c;
                exp_nxt    = e_c;
                if (e_c == '0) begin
                    result_nxt = {sign_r, 31'd0};
                    state_nxt  = S_PACK;
                end else if (m_c[MANT_W-1]) begin
                    result_nxt = fp_pack(sign_r, e_c, m_c[FRAC_W-1:0]);
                    state_nxt  = S_PACK;
                end
            end

            S_PACK: state_nxt = S_IDLE;

            default: state_nxt = S_IDLE;
        endcase

        // Handshake and adder controls are registered from the next state so
        // they line up with the state they belong to.
        en_nxt   = (state_nxt == S_LOAD) || (state_nxt == S_EXEC);
        load_nxt = (state_nxt == S_LOAD);
        pm_nxt   = en_nxt & eff_nxt;
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_PACK);
        done_nxt = (state_nxt == S_PACK);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= 1'b0;
            sign_r   <= 1'b0;
            eff_r    <= 1'b0;
            exp_r    <= '0;
            mant_l   <= '0;
            mant_s   <= '0;
            mant_r   <= '0;
            d_r      <= '0;
            result_r <= '0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
            en_r     <= 1'b0;
            load_r   <= 1'b0;
            pm_r     <= 1'b0;
        end else begin
            state    <= state_nxt;
            a_r      <= a_nxt;
            b_r      <= b_nxt;
            op_r     <= op_nxt;
            sign_r   <= sign_nxt;
            eff_r    <= eff_nxt;
            exp_r    <= exp_nxt;
            mant_l   <= mant_l_nxt;
            mant_s   <= mant_s_nxt;
            mant_r   <= mant_r_nxt;
            d_r      <= d_nxt;
            result_r <= result_nxt;
            busy_r   <= busy_nxt;
            done_r   <= done_nxt;
            en_r     <= en_nxt;
            load_r   <= load_nxt;
            pm_r     <= pm_nxt;
        end
    end

    assign bus.busy   = busy_r;
    assign bus.done   = done_r;
    assign bus.result = result_r;

    assign add_en    = en_r;
    assign add_load  = load_r;
    assign add_pm    = pm_r;
    assign add_a     = mant_l;
    assign add_b     = mant_s;
    assign add_signa = 1'b0;
    assign add_signb = 1'b0;
    assign add_cin   = 1'b0;

endmodule

// File: tb/tb_fp_addsub_ctrl.sv
// tb/tb_fp_addsub_ctrl.sv - self-checking bench for fp_addsub_ctrl with a behavioural mantissa adder
module tb_fp_addsub_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fp_addsub_ctrl_if bus();

    logic        add_en, add_load, add_pm, add_signa, add_signb, add_cin, add_cout;
    logic [23:0] add_a, add_b, add_sum;

    fp_addsub_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .add_en    (add_en),
        .add_load  (add_load),
        .add_pm    (add_pm),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_signa (add_signa),
        .add_signb (add_signb),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    // Stand-in for fullAdder32: registers the sum at the end of the compute cycle.
    always @(posedge clk) begin
        if (!rst) begin
            add_sum  <= '0;
            add_cout <= 1'b0;
        end else if (add_en && !add_load) begin
            if (add_pm) begin
                add_sum  <= add_a - add_b;
                add_cout <= 1'b0;
            end else begin
                {add_cout, add_sum} <= {1'b0, add_a} + {1'b0, add_b};
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer significands, truncating alignment, then normalise.
    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic op);
        logic   sa, sb, sl;
        int     ea, eb, el, es, e;
        longint ma, mb, ml, ms, r;
        sa = a[31];
        sb = b[31] ^ op;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        if ((ea == 255 && a[22:0] != 0) || (eb == 255 && b[22:0] != 0)) return 32'h7FC00000;
        if (ea == 255 && eb == 255) return (sa != sb) ? 32'h7FC00000 : {sa, 31'h7F800000};
        if (ea == 255) return {sa, 31'h7F800000};
        if (eb == 255) return {sb, 31'h7F800000};
        ma = (ea == 0) ? 64'd0 : longint'({1'b1, a[22:0]});
        mb = (eb == 0) ? 64'd0 : longint'({1'b1, b[22:0]});
        if (ma == 0 && mb == 0) return {sa & sb, 31'd0};
        if (eb > ea || (eb == ea && mb > ma)) begin
            el = eb; ml = mb; es = ea; ms = mb; ms = ma; sl = sb;
        end else begin
            el = ea; ml = ma; es = eb; ms = mb; sl = sa;
        end
        r = (el - es > 24) ? 64'd0 : (ms >> (el - es));
        r = (sa != sb) ? (ml - r) : (ml + r);
        if (r == 0) return 32'h0;
        e = el;
        if (r >= 64'd16777216) begin
            r = r >> 1;
            e++;
        end
        while (r < 64'd8388608) begin
            r = r << 1;
            e--;
            if (e == 0) return {sl, 31'd0};
        end
        if (e >= 255) return {sl, 31'h7F800000};
        return {sl, e[7:0], r[22:0]};
    endfunction

    logic [31:0] exp_q[$];

    // Every done pulse is checked against the reference model.
    always @(negedge clk) begin
        if (rst && bus.done) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got result %h, expected no done", bus.result);
            end else begin
                check("model_result", bus.result, exp_q.pop_front());
                check("busy_low_at_done", {31'd0, bus.busy}, 32'd0);
                check("tied_low_inputs", {29'd0, add_signa, add_signb, add_cin}, 32'd0);
            end
        end
    end

    logic        ld_seen;
    logic [23:0] ld_a, ld_b;
    logic        ld_pm;

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b, input logic op,
                          input logic [31:0] lit, input int lat_lit, input bit poke);
        int lat;
        exp_q.push_back(model(a, b, op));
        ld_seen = 1'b0;
        @(posedge clk); #1;
        bus.a = a; bus.b = b; bus.op = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        lat = 1;
        check({name, "_busy"}, {31'd0, bus.busy}, 32'd1);
        while (!bus.done && lat < 200) begin
            if (poke && lat == 2) begin
                bus.start = 1'b1; bus.a = 32'h3F800000; bus.b = 32'h3F800000;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
            if (add_load) begin
                ld_seen = 1'b1; ld_a = add_a; ld_b = add_b; ld_pm = add_pm;
            end
        end
        bus.start = 1'b0;
        if (!bus.done) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s_timeout: no done after %0d cycles, expected done", name, lat);
        end else begin
            check({name, "_result"}, bus.result, lit);
            if (lat_lit >= 0) check({name, "_latency"}, lat, lat_lit);
        end
        @(posedge clk); #1;
        check({name, "_idle_after"}, {30'd0, bus.busy, bus.done}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.start = 1'b0; bus.op = 1'b0; bus.a = '0; bus.b = '0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {27'd0, bus.busy, bus.done, add_en, add_load, add_pm}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_add_a", {8'd0, add_a}, 32'd0);
        check("reset_add_b", {8'd0, add_b}, 32'd0);
        rst = 1'b1;

        run_op("add_carry",   32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6, 1'b0);
        run_op("sub_align1",  32'h40400000, 32'h3F800000, 1'b1, 32'h40000000, 6, 1'b0);
        check("sub_align1_load_seen", {31'd0, ld_seen}, 32'd1);
        check("sub_align1_pm", {31'd0, ld_pm}, 32'd1);
        check("sub_align1_add_a", {8'd0, ld_a}, 32'h00C00000);
        check("sub_align1_add_b", {8'd0, ld_b}, 32'h00400000);
        run_op("cancel",      32'h3F800000, 32'hBF800000, 1'b0, 32'h00000000, 6, 1'b0);
        run_op("swap_d24",    32'h3F800000, 32'h4B800000, 1'b0, 32'h4B800000, 29, 1'b0);
        check("swap_d24_add_a", {8'd0, ld_a}, 32'h00800000);
        check("swap_d24_add_b", {8'd0, ld_b}, 32'h00000000);
        check("swap_d24_pm", {31'd0, ld_pm}, 32'd0);
        run_op("overflow",    32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 6, 1'b0);
        run_op("nan_in",      32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 2, 1'b0);
        run_op("norm2",       32'h3FC00000, 32'h3FA00000, 1'b1, 32'h3E800000, 8, 1'b0);
        run_op("neg_swap",    32'hC0400000, 32'h40A00000, 1'b0, 32'h40000000, 7, 1'b1);
        run_op("neg_zeros",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 2, 1'b0);
        run_op("nzero_sub",   32'h80000000, 32'h00000000, 1'b1, 32'h80000000, 2, 1'b0);
        run_op("inf_m_inf",   32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 2, 1'b0);
        run_op("one_m_inf",   32'h3F800000, 32'h7F800000, 1'b1, 32'hFF800000, 2, 1'b0);
        run_op("denorm",      32'h3F800000, 32'h00000001, 1'b0, 32'h3F800000, -1, 1'b0);
        run_op("max_norm",    32'h3F800000, 32'h3F7FFFFF, 1'b1, 32'h34000000, 29, 1'b0);
        run_op("underflow",   32'h00800001, 32'h00800000, 1'b1, 32'h00000000, 7, 1'b0);

        // Abort mid-alignment: no done may follow, state must clear.
        @(posedge clk); #1;
        bus.a = 32'h4B800000; bus.b = 32'h3F800000; bus.op = 1'b0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_ctrl", {29'd0, bus.busy, bus.done, add_en}, 32'd0);
        check("abort_result", bus.result, 32'd0);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        run_op("after_abort", 32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 6, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
